// File: rtl/display_scan_ctrl.sv
// Digit-scan sequencer with anti-ghost blanking and a frame-synchronous double
// buffer for the hex display word, so a frame never shows torn data.
module display_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] hexs_in,
  input  logic [3:0]  point_in,
  input  logic [3:0]  les_in,
  output logic [1:0]  Scan,
  output logic [15:0] Hexs,
  output logic [3:0]  Point,
  output logic [3:0]  LES,
  output logic        blank,
  output logic        pending,
  output logic        frame_done
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST    = CW'(PRESCALE - 1);
  localparam logic [CW:0]   BLANK_C = (CW+1)'(BLANK);
  localparam logic          BLANK_RST = (BLANK > 0);

  typedef struct packed {
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
  } word_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    scan_q, scan_d;
  logic          blank_q, blank_d;
  logic          pend_q, pend_d;
  logic          fdone_q;
  word_t         buf_q, buf_d, act_q, act_d, in_w;
  logic          wrap, boundary;

  assign in_w = '{hexs: hexs_in, point: point_in, les: les_in};

  always_comb begin
    wrap     = en && (cnt_q == LAST);
    boundary = wrap && (scan_q == 2'd3);
    cnt_d    = cnt_q;
    scan_d   = scan_q;
    if (en) cnt_d = wrap ? '0 : cnt_q + CW'(1);
    if (wrap) scan_d = scan_q + 2'd1;
    // Blank is registered from the next count so it never glitches on cnt decode.
    blank_d  = ({1'b0, cnt_d} < BLANK_C);

    buf_d  = buf_q;
    pend_d = pend_q;
    act_d  = act_q;
    if (boundary) begin
      // A load landing on the boundary bypasses the buffer entirely.
      if (load)        act_d = in_w;
      else if (pend_q) act_d = buf_q;
      pend_d = 1'b0;
    end else if (load) begin
      buf_d  = in_w;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      scan_q  <= '0;
      blank_q <= BLANK_RST;
      pend_q  <= 1'b0;
      fdone_q <= 1'b0;
      buf_q   <= '0;
      act_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      blank_q <= blank_d;
      pend_q  <= pend_d;
      fdone_q <= boundary;
      buf_q   <= buf_d;
      act_q   <= act_d;
    end
  end

  assign Scan       = scan_q;
  assign Hexs       = act_q.hexs;
  assign Point      = act_q.point;
  assign LES        = act_q.les;
  assign blank      = blank_q | ~en;
  assign pending    = pend_q;
  assign frame_done = fdone_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench: stimulus pushes the word expected at each frame commit; a
// negedge monitor pops it whenever frame_done pulses.
module tb_display_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] hexs_in;
  logic [3:0]  point_in, les_in;
  logic [1:0]  Scan;
  logic [15:0] Hexs;
  logic [3:0]  Point, LES;
  logic        blank, pending, frame_done;

  typedef struct packed {
    logic [15:0] h;
    logic [3:0]  p;
    logic [3:0]  l;
  } word_t;

  word_t exp_q[$];
  int checks = 0;
  int failures = 0;

  display_scan_ctrl #(.PRESCALE(4), .BLANK(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .hexs_in(hexs_in), .point_in(point_in), .les_in(les_in),
    .Scan(Scan), .Hexs(Hexs), .Point(Point), .LES(LES),
    .blank(blank), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    load = 1'b1; hexs_in = h; point_in = p; les_in = l;
  endtask

  // Monitor: every frame commit must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && frame_done) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL frame_unexpected: frame_done with empty queue at %0t", $time);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        chk("frame_hexs", 32'(Hexs), 32'(e.h));
        chk("frame_point", 32'(Point), 32'(e.p));
        chk("frame_les", 32'(LES), 32'(e.l));
        chk("frame_scan", 32'(Scan), 32'd0);
        chk("frame_pending", 32'(pending), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0;
    hexs_in = '0; point_in = '0; les_in = '0;
    step(3);
    chk("rst_scan", 32'(Scan), 0);
    chk("rst_hexs", 32'(Hexs), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    chk("rst_blank", 32'(blank), 1);
    rst = 1'b0;

    // Free run: cycle k has Scan = k/4 mod 4, blank on first cycle of slot.
    exp_q.push_back('{h: 16'h0, p: 4'h0, l: 4'h0});
    exp_q.push_back('{h: 16'h0, p: 4'h0, l: 4'h0});
    for (int k = 0; k < 32; k++) begin
      chk("run_scan", 32'(Scan), 32'((k / 4) % 4));
      chk("run_blank", 32'(blank), 32'(k % 4 == 0));
      chk("run_fdone", 32'(frame_done), 32'(k % 16 == 0 && k > 0));
      step();
    end

    // Buffered load during Scan = 1 (cycle 36), commits at cycle 48.
    step(4);
    chk("bl_scan1", 32'(Scan), 1);
    do_load(16'h1234, 4'b0101, 4'hF);
    exp_q.push_back('{h: 16'h1234, p: 4'b0101, l: 4'hF});
    step();
    load = 1'b0;
    chk("bl_pending", 32'(pending), 1);
    chk("bl_hexs_hold", 32'(Hexs), 0);
    step(10);
    chk("bl_pre_hexs", 32'(Hexs), 0);
    chk("bl_pre_pending", 32'(pending), 1);
    step();
    chk("bl_fdone", 32'(frame_done), 1);
    chk("bl_hexs", 32'(Hexs), 32'h1234);

    // Overwrite within one frame: only the latest word is committed at 64.
    do_load(16'hAAAA, 4'h0, 4'hF);
    step();
    do_load(16'h5555, 4'h0, 4'hF);
    exp_q.push_back('{h: 16'h5555, p: 4'h0, l: 4'hF});
    step();
    load = 1'b0;
    chk("ow_hexs_hold", 32'(Hexs), 32'h1234);
    step(14);
    chk("ow_hexs", 32'(Hexs), 32'h5555);

    // Load on the boundary edge (end of cycle 79) commits directly.
    step(15);
    chk("bc_scan3", 32'(Scan), 3);
    do_load(16'hBEEF, 4'hA, 4'h3);
    exp_q.push_back('{h: 16'hBEEF, p: 4'hA, l: 4'h3});
    step();
    load = 1'b0;
    chk("bc_hexs", 32'(Hexs), 32'hBEEF);
    chk("bc_pending", 32'(pending), 0);

    // Enable freeze at Scan = 2, cnt = 1 with a load pending.
    step(4);
    do_load(16'h0F0F, 4'h1, 4'h1);
    exp_q.push_back('{h: 16'h0F0F, p: 4'h1, l: 4'h1});
    step();
    load = 1'b0;
    chk("ef_pending", 32'(pending), 1);
    step(4);
    chk("ef_scan2", 32'(Scan), 2);
    en = 1'b0;
    #1;
    chk("ef_blank_now", 32'(blank), 1);
    step(10);
    chk("ef_scan_hold", 32'(Scan), 2);
    chk("ef_blank", 32'(blank), 1);
    chk("ef_pending_hold", 32'(pending), 1);
    chk("ef_hexs_hold", 32'(Hexs), 32'hBEEF);
    en = 1'b1;
    step(2);
    chk("ef_resume_scan", 32'(Scan), 2);
    chk("ef_resume_blank", 32'(blank), 0);
    step();
    chk("ef_next_slot", 32'(Scan), 3);
    chk("ef_next_blank", 32'(blank), 1);
    step(4);
    chk("ef_commit", 32'(Hexs), 32'h0F0F);

    // Async reset between edges with a pending word and Scan = 3.
    step();
    do_load(16'hCAFE, 4'hF, 4'hF);
    step();
    load = 1'b0;
    step(10);
    chk("ar_scan3", 32'(Scan), 3);
    chk("ar_pending", 32'(pending), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_scan", 32'(Scan), 0);
    chk("ar_hexs", 32'(Hexs), 0);
    chk("ar_point", 32'(Point), 0);
    chk("ar_les", 32'(LES), 0);
    chk("ar_pend", 32'(pending), 0);
    chk("ar_fdone", 32'(frame_done), 0);
    chk("ar_blank", 32'(blank), 1);
    rst = 1'b0;
    // Discarded pending word must not appear at the next frame.
    exp_q.push_back('{h: 16'h0, p: 4'h0, l: 4'h0});
    step(16);
    chk("ar_fdone_after", 32'(frame_done), 1);
    step();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan sequencer and frame-buffer stage that drives the 4-digit hex display multiplexer. It generates the 2-bit digit-select `Scan` at a programmable slot rate and supplies an anti-ghosting blanking strobe. It also holds the displayed `Hexs`/`Point`/`LES` words in a double buffer, so that host updates take effect only at a frame boundary and a digit never shows torn data. Its outputs connect directly to the `Scan`, `Hexs`, `Point` and `LES` inputs of the display multiplexer. `blank` gates the anode drive downstream.

## Interface
Parameters:
- `PRESCALE`, default 50000: clock cycles per digit slot. Legal range is ≥ 2.
- `BLANK`, default 500: cycles at the start of each slot during which `blank` is high. Legal range is 0 ≤ BLANK < PRESCALE.

Ports:
- `clk`  in  1: system clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: scan enable. When low, the scan freezes and `blank` is forced high.
- `load`  in  1: single-cycle write strobe for the pending buffer.
- `hexs_in`  in  16: four 4-bit digit values. Digit 0 is bits [3:0].
- `point_in`  in  4: per-digit decimal point.
- `les_in`  in  4: per-digit enable.
- `Scan`  out  2: current digit slot, 0 to 3.
- `Hexs`  out  16: active display word.
- `Point`  out  4: active decimal points.
- `LES`  out  4: active digit enables.
- `blank`  out  1: high means downstream forces all anodes off.
- `pending`  out  1: a loaded word is waiting for the next frame boundary.
- `frame_done`  out  1: one-cycle pulse at the start of each new frame.

## Operation
- Reset values:
  - `cnt` = 0, `Scan` = 0, `Hexs` = 0, `Point` = 0, `LES` = 0.
  - `pending` = 0, `frame_done` = 0.
  - Pending buffer = 0.
  - `blank` = 1 if BLANK > 0 or `en` = 0.
- Slot counter `cnt`, width $clog2(PRESCALE):
  - While `en` = 1, `cnt` increments each cycle.
  - At PRESCALE−1, `cnt` wraps to 0 and `Scan` increments mod 4. 3 wraps to 0.
  - While `en` = 0, `cnt` and `Scan` hold.
- `blank` = (`cnt` < BLANK) | ~`en`. It is combinational from registered state and is glitch-free with respect to `cnt`.
- Frame boundary: the edge where `Scan` = 3, `cnt` = PRESCALE−1 and `en` = 1.
- Load path:
  - `load` = 1 captures `hexs_in`, `point_in` and `les_in` into the pending buffer and sets `pending`.
  - A second `load` while `pending` is set overwrites the buffer. Latest data wins.
- Commit:
  - At a frame boundary with `pending` = 1, the buffer copies to `Hexs`/`Point`/`LES` and `pending` clears.
  - With `pending` = 0, the active words hold.
- `load` coinciding with a frame boundary: the incoming `*_in` values commit directly to the active words at that edge, and `pending` ends at 0.
- `frame_done` is registered. It is high exactly in the cycle after a frame boundary, which is the first cycle of `Scan` = 0 with the new data visible.
- Active words never change except at a frame boundary or on reset.
- Reset mid-frame: all state returns to reset values immediately, regardless of `clk`. Pending data is discarded.

## Timing
- Slot length is PRESCALE cycles. A frame is 4·PRESCALE cycles while `en` is held high.
- `Scan` changes only on the edge where `cnt` wraps to 0. `blank` is therefore high in the first BLANK cycles of every slot, including the cycle `Scan` changes.
- Load-to-display latency: from the `load` edge to the next frame boundary edge, between 1 and 4·PRESCALE cycles with `en` = 1. Latency is 0 extra cycles if `load` falls on the boundary.
- `pending` rises the cycle after the `load` edge. It falls the cycle after the commit edge.
- Deasserting `en` mid-slot freezes `cnt`/`Scan` at their current values. Re-asserting `en` resumes counting from the frozen `cnt`, with no slot restart.
- A frame boundary cannot occur while `en` = 0. Pending data waits.

## Test plan
- **Reset and free-run.** Set PRESCALE = 4, BLANK = 1. Release `rst` and hold `en` = 1.
  - `Scan` sequence: 0,0,0,0,1,1,1,1,2,…,3 then 0.
  - `blank` is high on the first cycle of each slot only.
  - `frame_done` pulses every 16 cycles, coinciding with `Scan` returning to 0.
- **Buffered load.** Pulse `load` with `hexs_in` = 16'h1234, `point_in` = 4'b0101, `les_in` = 4'hF while `Scan` = 1.
  - `pending` = 1 next cycle. `Hexs` stays at 0 until the frame boundary.
  - Then `Hexs` = 16'h1234 and `pending` = 0, with `frame_done` high in the same cycle.
- **Overwrite.** Load 16'hAAAA, then 16'h5555, both within the same frame. Only 16'h5555 is ever visible on `Hexs`.
- **Boundary coincidence.** Pulse `load` (16'hBEEF) exactly on the frame-boundary edge. `Hexs` = 16'hBEEF on the next cycle and `pending` never rises.
- **Enable freeze.** Drop `en` at `Scan` = 2, `cnt` = 1 for 10 cycles.
  - `Scan`/`cnt` hold, `blank` = 1, and a pending load does not commit.
  - On `en` = 1, counting resumes from `cnt` = 1.
- **Async reset mid-frame.** Assert `rst` between clock edges with `pending` = 1 and `Scan` = 3. All outputs take their reset values before the next `clk` edge.
